// File: rtl/stn_capture.sv
// stn_capture
//   Captures the 4-bit STN panel stream (FPFRAME/FPLINE/FPSHIFT/FPDAT) and
//   turns pairs of nibbles into byte-wide line-buffer writes tagged with
//   their byte column and line number.
//
//   Optional feature macro: STN_CAPTURE_SYNC_EN
//     defined   : every panel input passes a 2-flop synchronizer before the
//                 sampling register (fully asynchronous panel inputs).
//     undefined : single sampling register (inputs synchronous to clk).
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   fpframe, fpline   frame / line pulses from the panel stream
//   fpshift           shift clock, data taken on its falling edge
//   fpdat[3:0]        data nibble
//   wr_en             one-cycle byte write strobe
//   wr_x, wr_y        byte column / line of wr_dat (held between strobes)
//   wr_dat[7:0]       assembled byte, first nibble in [7:4]
//   frame_start       pulse on FPFRAME rising edge
//   line_done         pulse on FPLINE falling edge while capturing
//   err_ovf           sticky: byte or line beyond the frame bounds dropped
//   err_odd           sticky: a line ended on a half byte
module stn_capture #(
    parameter int H_BYTES = 40,
    parameter int V_LINES = 240,
    parameter int XW      = 6,
    parameter int YW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fpframe,
    input  logic          fpline,
    input  logic          fpshift,
    input  logic [3:0]    fpdat,
    output logic          wr_en,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic [7:0]    wr_dat,
    output logic          frame_start,
    output logic          line_done,
    output logic          err_ovf,
    output logic          err_odd
);

    // Position counters are one bit wider than the outputs so they can
    // saturate at H_BYTES / V_LINES without wrapping.
    localparam logic [XW:0] XMAX = (XW+1)'(H_BYTES);
    localparam logic [YW:0] YMAX = (YW+1)'(V_LINES);

    typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

    // {fpframe, fpline, fpshift, fpdat[3:0]}
    logic [6:0] raw;
    logic [6:0] smp_q;
    logic [6:0] prev_q;

    assign raw = {fpframe, fpline, fpshift, fpdat};

`ifdef STN_CAPTURE_SYNC_EN
    logic [6:0] sync1_q;
    logic [6:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            smp_q   <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            smp_q   <= sync2_q;
            prev_q  <= smp_q;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q  <= '0;
            prev_q <= '0;
        end else begin
            smp_q  <= raw;
            prev_q <= smp_q;
        end
    end
`endif

    logic       frame_rise;
    logic       line_fall;
    logic       shift_fall;
    logic [3:0] nib;

    assign frame_rise = smp_q[6] & ~prev_q[6];
    assign line_fall  = ~smp_q[5] & prev_q[5];
    assign shift_fall = ~smp_q[4] & prev_q[4];
    assign nib        = smp_q[3:0];

    state_t        state_q, state_d;
    logic [XW:0]   x_q, x_d;
    logic [YW:0]   y_q, y_d;
    logic          phase_q, phase_d;
    logic [3:0]    hold_q, hold_d;
    logic          wr_en_q, wr_en_d;
    logic [XW-1:0] wr_x_q, wr_x_d;
    logic [YW-1:0] wr_y_q, wr_y_d;
    logic [7:0]    wr_dat_q, wr_dat_d;
    logic          fs_q, fs_d;
    logic          ld_q, ld_d;
    logic          ovf_q, ovf_d;
    logic          odd_q, odd_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_FRAME;
            x_q      <= '0;
            y_q      <= '0;
            phase_q  <= 1'b0;
            hold_q   <= '0;
            wr_en_q  <= 1'b0;
            wr_x_q   <= '0;
            wr_y_q   <= '0;
            wr_dat_q <= '0;
            fs_q     <= 1'b0;
            ld_q     <= 1'b0;
            ovf_q    <= 1'b0;
            odd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            phase_q  <= phase_d;
            hold_q   <= hold_d;
            wr_en_q  <= wr_en_d;
            wr_x_q   <= wr_x_d;
            wr_y_q   <= wr_y_d;
            wr_dat_q <= wr_dat_d;
            fs_q     <= fs_d;
            ld_q     <= ld_d;
            ovf_q    <= ovf_d;
            odd_q    <= odd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        phase_d  = phase_q;
        hold_d   = hold_q;
        wr_en_d  = 1'b0;
        wr_x_d   = wr_x_q;
        wr_y_d   = wr_y_q;
        wr_dat_d = wr_dat_q;
        fs_d     = 1'b0;
        ld_d     = 1'b0;
        ovf_d    = ovf_q;
        odd_d    = odd_q;

        // A frame edge restarts capture and swallows any coincident
        // shift/line edge in the same cycle.
        if (frame_rise) begin
            fs_d    = 1'b1;
            x_d     = '0;
            y_d     = '0;
            phase_d = 1'b0;
            ovf_d   = 1'b0;
            odd_d   = 1'b0;
            state_d = ACTIVE;
        end else if (state_q == ACTIVE) begin
            if (shift_fall) begin
                if (!phase_q) begin
                    hold_d  = nib;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (x_q < XMAX && y_q < YMAX) begin
                        wr_en_d  = 1'b1;
                        wr_x_d   = x_q[XW-1:0];
                        wr_y_d   = y_q[YW-1:0];
                        wr_dat_d = {hold_q, nib};
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (x_q < XMAX)
                        x_d = x_q + 1'b1;
                end
            end
            // Line end is applied after the nibble above, so a byte
            // completed on the same cycle lands at the old x/y.
            if (line_fall) begin
                ld_d = 1'b1;
                if (phase_d)
                    odd_d = 1'b1;
                x_d     = '0;
                phase_d = 1'b0;
                if (y_q < YMAX)
                    y_d = y_q + 1'b1;
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_x        = wr_x_q;
    assign wr_y        = wr_y_q;
    assign wr_dat      = wr_dat_q;
    assign frame_start = fs_q;
    assign line_done   = ld_q;
    assign err_ovf     = ovf_q;
    assign err_odd     = odd_q;

endmodule

// File: tb/tb_stn_capture.sv
module tb_stn_capture;

    localparam int H = 40;
    localparam int V = 240;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fpframe = 1'b0;
    logic       fpline = 1'b0;
    logic       fpshift = 1'b1;
    logic [3:0] fpdat = 4'h0;
    logic       wr_en;
    logic [5:0] wr_x;
    logic [7:0] wr_y;
    logic [7:0] wr_dat;
    logic       frame_start;
    logic       line_done;
    logic       err_ovf;
    logic       err_odd;

    stn_capture #(.H_BYTES(H), .V_LINES(V), .XW(6), .YW(8)) dut (
        .clk(clk), .rst(rst), .fpframe(fpframe), .fpline(fpline),
        .fpshift(fpshift), .fpdat(fpdat), .wr_en(wr_en), .wr_x(wr_x),
        .wr_y(wr_y), .wr_dat(wr_dat), .frame_start(frame_start),
        .line_done(line_done), .err_ovf(err_ovf), .err_odd(err_odd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] x;
        logic [7:0] y;
        logic [7:0] d;
    } wr_t;

    int total = 0;
    int bad   = 0;

    // Behavioural model: counts nibbles per line and lines per frame;
    // byte k of a line is nibbles 2k,2k+1 and is kept only inside the frame.
    wr_t  expq[$];
    wr_t  last = '0;
    int   m_active = 0, m_nib = 0, m_line = 0, m_ovf = 0, m_odd = 0;
    int   m_fs = 0, m_ld = 0;
    logic [3:0] m_first = 4'h0;
    int   obs_fs = 0, obs_ld = 0, obs_wr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic tick();
        wr_t got;
        @(posedge clk);
        #1;
        got = {wr_x, wr_y, wr_dat};
        if (wr_en === 1'b1) begin
            obs_wr++;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wr: got %0h expected no write", got);
            end else begin
                last = expq.pop_front();
                chk("wr", 32'(got), 32'(last));
            end
        end else begin
            chk("hold", 32'(got), 32'(last));
        end
        if (frame_start === 1'b1) obs_fs++;
        if (line_done === 1'b1) obs_ld++;
    endtask

    task automatic m_nibble(input logic [3:0] d);
        int k;
        if (m_active != 0) begin
            m_nib++;
            if (m_nib % 2 == 1) begin
                m_first = d;
            end else begin
                k = m_nib / 2 - 1;
                if (k < H && m_line < V)
                    expq.push_back({6'(k), 8'(m_line), m_first, d});
                else
                    m_ovf = 1;
            end
        end
    endtask

    task automatic m_lineend();
        if (m_active != 0) begin
            m_ld++;
            if (m_nib % 2 == 1) m_odd = 1;
            m_nib = 0;
            m_line++;
        end
    endtask

    task automatic hold_n();
        repeat (4 + $urandom_range(0, 1)) tick();
    endtask

    task automatic shift(input logic [3:0] d);
        fpdat = d;
        fpshift = 1'b0;
        m_nibble(d);
        hold_n();
        fpshift = 1'b1;
        hold_n();
    endtask

    task automatic line_pulse();
        fpline = 1'b1;
        hold_n();
        fpline = 1'b0;
        m_lineend();
        hold_n();
    endtask

    // Shift fall and line fall on the same cycle.
    task automatic shift_line(input logic [3:0] d);
        fpline = 1'b1;
        hold_n();
        fpdat = d;
        fpshift = 1'b0;
        fpline = 1'b0;
        m_nibble(d);
        m_lineend();
        hold_n();
        fpshift = 1'b1;
        hold_n();
    endtask

    task automatic frame_pulse();
        fpframe = 1'b1;
        m_active = 1;
        m_fs++;
        m_nib = 0;
        m_line = 0;
        m_ovf = 0;
        m_odd = 0;
        hold_n();
        fpframe = 1'b0;
        hold_n();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_active = 0;
        m_nib = 0;
        m_line = 0;
        m_ovf = 0;
        m_odd = 0;
        last = '0;
        expq.delete();
        fpshift = 1'b1;
        fpline = 1'b0;
        fpframe = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic checkpoint(input string tag);
        chk({tag, "_ovf"}, 32'(err_ovf), 32'(m_ovf));
        chk({tag, "_odd"}, 32'(err_odd), 32'(m_odd));
        chk({tag, "_fs"}, 32'(obs_fs), 32'(m_fs));
        chk({tag, "_ld"}, 32'(obs_ld), 32'(m_ld));
        chk({tag, "_pending"}, 32'(expq.size()), 32'd0);
    endtask

    initial begin
        int w0;
        int n;
        logic [3:0] r;

        // Reset values
        do_reset();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_outs", 32'({wr_x, wr_y, wr_dat}), 32'd0);
        chk("rst_flags", 32'({frame_start, line_done, err_ovf, err_odd}), 32'd0);

        // T1: shifts before any frame are ignored
        shift(4'h5);
        shift(4'h5);
        checkpoint("t1");
        chk("t1_nowr", 32'(obs_wr), 32'd0);

        // T2: first frame, two bytes
        frame_pulse();
        shift(4'h5); shift(4'h5); shift(4'h3); shift(4'h4);
        checkpoint("t2");
        chk("t2_fs", 32'(obs_fs), 32'd1);
        chk("t2_wr", 32'(obs_wr), 32'd2);
        chk("t2_last", 32'({wr_x, wr_y, wr_dat}), 32'({6'd1, 8'd0, 8'h34}));

        // T3: two full lines
        frame_pulse();
        w0 = obs_wr;
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 80; i++) shift(4'($urandom));
            line_pulse();
        end
        checkpoint("t3");
        chk("t3_wr", 32'(obs_wr - w0), 32'd80);
        chk("t3_xy", 32'({wr_x, wr_y}), 32'({6'd39, 8'd1}));
        chk("t3_err", 32'({err_ovf, err_odd}), 32'd0);

        // T4: over-long line
        frame_pulse();
        w0 = obs_wr;
        for (int i = 0; i < 82; i++) shift(4'($urandom));
        line_pulse();
        checkpoint("t4");
        chk("t4_wr", 32'(obs_wr - w0), 32'd40);
        chk("t4_ovf", 32'(err_ovf), 32'd1);
        chk("t4_x", 32'(wr_x), 32'd39);
        frame_pulse();
        chk("t4_clr", 32'(err_ovf), 32'd0);

        // T5: odd line, next line starts clean
        w0 = obs_wr;
        shift(4'h1); shift(4'h2); shift(4'h3);
        line_pulse();
        checkpoint("t5");
        chk("t5_odd", 32'(err_odd), 32'd1);
        chk("t5_wr", 32'(obs_wr - w0), 32'd1);
        shift(4'h6); shift(4'h7);
        checkpoint("t5b");
        chk("t5_next", 32'({wr_x, wr_y, wr_dat}), 32'({6'd0, 8'd1, 8'h67}));

        // T6: coincident shift and line fall completes the byte first
        frame_pulse();
        shift(4'h8);
        shift_line(4'h9);
        checkpoint("t6");
        chk("t6_wr", 32'({wr_x, wr_y, wr_dat}), 32'({6'd0, 8'd0, 8'h89}));
        chk("t6_odd", 32'(err_odd), 32'd0);

        // T7: reset mid-line, no capture until next frame
        shift(4'hA);
        do_reset();
        w0 = obs_wr;
        for (int i = 0; i < 4; i++) shift(4'($urandom));
        chk("t7_nowr", 32'(obs_wr - w0), 32'd0);
        chk("t7_outs", 32'({wr_x, wr_y, wr_dat, err_ovf, err_odd}), 32'd0);

        // T8: random lines
        frame_pulse();
        for (int l = 0; l < 6; l++) begin
            n = $urandom_range(0, 84);
            for (int i = 0; i < n; i++) shift(4'($urandom));
            r = 4'($urandom);
            if ($urandom_range(0, 1) == 1) shift_line(r);
            else line_pulse();
        end
        checkpoint("t8");

        // T9: bytes beyond the last line are dropped
        frame_pulse();
        repeat (V + 1) line_pulse();
        shift(4'h1); shift(4'h2);
        checkpoint("t9");
        chk("t9_ovf", 32'(err_ovf), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
